// File: rtl/fg_island_prog_sequencer.sv
// Programming sequencer for one floating-gate island: mode switching, row/column
// selection, injection pulse trains, global tunnel and single-cell measurement.
`timescale 1ns/1ps
module fg_island_prog_sequencer #(
    parameter int unsigned ROW_BITS   = 3,
    parameter int unsigned COL_BITS   = 4,
    parameter int unsigned NUM_COLS   = 10,
    parameter int unsigned SETTLE_CYC = 16,
    parameter int unsigned MEAS_CYC   = 64,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [ROW_BITS-1:0] cmd_row,
    input  logic [COL_BITS-1:0] cmd_col,
    input  logic [CNT_W-1:0]    cmd_npulse,
    input  logic [CNT_W-1:0]    cmd_pwidth,
    input  logic                abort,
    input  logic [15:0]         meas_data,
    output logic                rsp_valid,
    output logic [1:0]          rsp_status,
    output logic [15:0]         rsp_data,
    output logic                prog_mode,
    output logic                vdec_en,
    output logic [ROW_BITS-1:0] vdec_addr,
    output logic                hdec_en,
    output logic [COL_BITS-1:0] hdec_addr,
    output logic                vinj_pulse,
    output logic                vtun_en,
    output logic                meas_strobe,
    output logic                busy
);
    localparam int unsigned TW  = (2 * CNT_W > 24) ? 2 * CNT_W : 24;
    localparam int unsigned CW1 = COL_BITS + 1;

    localparam logic [1:0] OP_NOP     = 2'd0;
    localparam logic [1:0] OP_INJECT  = 2'd1;
    localparam logic [1:0] OP_TUNNEL  = 2'd2;
    localparam logic [1:0] OP_MEASURE = 2'd3;
    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_BAD     = 2'd1;
    localparam logic [1:0] ST_ABORT   = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE, S_MODE, S_SELECT, S_PULSE_HI, S_PULSE_LO,
        S_TUNNEL, S_MEAS, S_DESELECT, S_UNMODE, S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [TW-1:0]       cnt_q, cnt_d, tun_len_q, tun_len_d;
    logic [CNT_W-1:0]    pcnt_q, pcnt_d, npulse_q, npulse_d, pwidth_q, pwidth_d;
    logic [1:0]          op_q, op_d, status_q, status_d;
    logic [15:0]         data_q, data_d;
    logic [ROW_BITS-1:0] vaddr_q, vaddr_d;
    logic [COL_BITS-1:0] haddr_q, haddr_d;
    logic                cmd_ready_q, cmd_ready_d, busy_q, busy_d;
    logic                prog_mode_q, prog_mode_d, ven_q, ven_d, hen_q, hen_d;
    logic                vinj_q, vinj_d, vtun_q, vtun_d, strobe_q, strobe_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [1:0]          rsp_status_q, rsp_status_d;
    logic [15:0]         rsp_data_q, rsp_data_d;

    logic [CNT_W-1:0] np_in, pw_in;
    logic             col_bad, settle_done, pw_done, active_st, sel_st;

    assign np_in       = (cmd_npulse == '0) ? CNT_W'(1) : cmd_npulse;
    assign pw_in       = (cmd_pwidth == '0) ? CNT_W'(1) : cmd_pwidth;
    assign col_bad     = CW1'(cmd_col) >= CW1'(NUM_COLS);
    assign settle_done = cnt_q == TW'(SETTLE_CYC - 1);
    assign pw_done     = cnt_q == (TW'(pwidth_q) - TW'(1));
    assign active_st   = state_q inside {S_MODE, S_SELECT, S_PULSE_HI, S_PULSE_LO,
                                         S_TUNNEL, S_MEAS};

    // Next-state, counters and registered-output values
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + TW'(1);
        pcnt_d    = pcnt_q;
        op_d      = op_q;
        npulse_d  = npulse_q;
        pwidth_d  = pwidth_q;
        tun_len_d = tun_len_q;
        status_d  = status_q;
        data_d    = data_q;
        vaddr_d   = vaddr_q;
        haddr_d   = haddr_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (cmd_valid) begin
                    op_d      = cmd_op;
                    npulse_d  = np_in;
                    pwidth_d  = pw_in;
                    tun_len_d = TW'(np_in) * TW'(pw_in);
                    pcnt_d    = '0;
                    status_d  = ST_OK;
                    data_d    = '0;
                    if (cmd_op == OP_NOP) begin
                        state_d = S_RESP;
                    end else if (cmd_op != OP_TUNNEL && col_bad) begin
                        state_d  = S_RESP;
                        status_d = ST_BAD;
                    end else begin
                        state_d = S_MODE;
                        if (cmd_op != OP_TUNNEL) begin
                            vaddr_d = cmd_row;
                            haddr_d = cmd_col;
                        end
                    end
                end
            end
            S_MODE:     if (settle_done) state_d = S_SELECT;
            S_SELECT: begin
                if (settle_done) begin
                    pcnt_d = '0;
                    case (op_q)
                        OP_INJECT: state_d = S_PULSE_HI;
                        OP_TUNNEL: state_d = S_TUNNEL;
                        default:   state_d = S_MEAS;
                    endcase
                end
            end
            S_PULSE_HI: if (pw_done) state_d = S_PULSE_LO;
            S_PULSE_LO: begin
                if (pw_done) begin
                    if (pcnt_q == npulse_q - CNT_W'(1)) begin
                        state_d = S_DESELECT;
                    end else begin
                        pcnt_d  = pcnt_q + CNT_W'(1);
                        state_d = S_PULSE_HI;
                    end
                end
            end
            S_TUNNEL:   if (cnt_q == tun_len_q - TW'(1)) state_d = S_DESELECT;
            S_MEAS: begin
                if (cnt_q == TW'(MEAS_CYC + 1)) begin
                    state_d = S_DESELECT;
                    data_d  = meas_data;
                end
            end
            S_DESELECT: if (settle_done) state_d = S_UNMODE;
            S_UNMODE:   if (settle_done) state_d = S_RESP;
            default:    state_d = S_IDLE;
        endcase

        // Abort unwinds through the full deselect/unmode settle path
        if (abort && active_st) begin
            state_d  = S_DESELECT;
            status_d = ST_ABORT;
            data_d   = data_q;
        end else if (abort && (state_q == S_DESELECT || state_q == S_UNMODE)) begin
            status_d = ST_ABORT;
        end

        if (state_d != state_q) cnt_d = '0;
        if (state_d == S_UNMODE) begin
            vaddr_d = '0;
            haddr_d = '0;
        end

        sel_st       = state_d inside {S_SELECT, S_PULSE_HI, S_PULSE_LO, S_TUNNEL, S_MEAS};
        prog_mode_d  = (state_d inside {S_MODE, S_SELECT, S_PULSE_HI, S_PULSE_LO, S_TUNNEL,
                                        S_MEAS, S_DESELECT}) && (op_d != OP_MEASURE);
        ven_d        = sel_st && (op_d != OP_TUNNEL);
        hen_d        = sel_st && (op_d != OP_TUNNEL);
        vinj_d       = state_d == S_PULSE_HI;
        vtun_d       = state_d == S_TUNNEL;
        strobe_d     = (state_d == S_MEAS) && (cnt_d == TW'(MEAS_CYC));
        rsp_valid_d  = state_d == S_RESP;
        rsp_status_d = (state_d == S_RESP) ? status_d : ST_OK;
        rsp_data_d   = (state_d == S_RESP) ? data_d : 16'd0;
        cmd_ready_d  = state_d == S_IDLE;
        busy_d       = state_d != S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            tun_len_q    <= '0;
            pcnt_q       <= '0;
            npulse_q     <= '0;
            pwidth_q     <= '0;
            op_q         <= OP_NOP;
            status_q     <= ST_OK;
            data_q       <= '0;
            vaddr_q      <= '0;
            haddr_q      <= '0;
            cmd_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            prog_mode_q  <= 1'b0;
            ven_q        <= 1'b0;
            hen_q        <= 1'b0;
            vinj_q       <= 1'b0;
            vtun_q       <= 1'b0;
            strobe_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_status_q <= ST_OK;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tun_len_q    <= tun_len_d;
            pcnt_q       <= pcnt_d;
            npulse_q     <= npulse_d;
            pwidth_q     <= pwidth_d;
            op_q         <= op_d;
            status_q     <= status_d;
            data_q       <= data_d;
            vaddr_q      <= vaddr_d;
            haddr_q      <= haddr_d;
            cmd_ready_q  <= cmd_ready_d;
            busy_q       <= busy_d;
            prog_mode_q  <= prog_mode_d;
            ven_q        <= ven_d;
            hen_q        <= hen_d;
            vinj_q       <= vinj_d;
            vtun_q       <= vtun_d;
            strobe_q     <= strobe_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_status_q <= rsp_status_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign busy        = busy_q;
    assign prog_mode   = prog_mode_q;
    assign vdec_en     = ven_q;
    assign hdec_en     = hen_q;
    assign vdec_addr   = vaddr_q;
    assign hdec_addr   = haddr_q;
    // High-voltage gates are killed combinationally the moment abort is seen
    assign vinj_pulse  = vinj_q & ~abort;
    assign vtun_en     = vtun_q & ~abort;
    assign meas_strobe = strobe_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_status  = rsp_status_q;
    assign rsp_data    = rsp_data_q;
endmodule
